// File: rtl/pipe_collision_ctrl.sv
// Pipe scroller and collision detector for the bird game: moves one pipe pair per Tick,
// flags pipe/floor hits to the physics block via Stop/Ack, keeps score and a random gap height.
module pipe_collision_ctrl #(
  parameter logic [9:0] SCREEN_W = 10'd640,
  parameter logic [9:0] FLOOR_Y  = 10'd480,
  parameter logic [9:0] PIPE_W   = 10'd60,
  parameter logic [9:0] GAP_H    = 10'd120,
  parameter logic [9:0] GAP_MIN  = 10'd40,
  parameter logic [9:0] SPEED    = 10'd4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_ack,
  input  logic       i_tick,
  input  logic [9:0] i_bird_x_l,
  input  logic [9:0] i_bird_x_r,
  input  logic [9:0] i_bird_y_t,
  input  logic [9:0] i_bird_y_b,
  output logic       o_stop,
  output logic [9:0] o_pipe_x_l,
  output logic [9:0] o_pipe_x_r,
  output logic [9:0] o_gap_y_t,
  output logic [9:0] o_gap_y_b,
  output logic [7:0] o_score,
  output logic       o_q_idle,
  output logic       o_q_run,
  output logic       o_q_hit
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_HIT  = 3'b100
  } state_t;

  state_t     r_state;
  logic [9:0] r_pipe_x_l;
  logic [9:0] r_pipe_x_r;
  logic [9:0] r_gap_y_t;
  logic [9:0] r_gap_y_b;
  logic [7:0] r_score;
  logic       r_scored;
  logic [7:0] r_lfsr;

  logic       w_xov;
  logic       w_ingap;
  logic       w_hit;
  logic       w_score_evt;
  logic       w_lfsr_fb;
  logic [9:0] w_gap_new;

  always_comb begin
    w_xov       = (i_bird_x_r > r_pipe_x_l) && (i_bird_x_l < r_pipe_x_r);
    w_ingap     = (i_bird_y_t >= r_gap_y_t) && (i_bird_y_b <= r_gap_y_b);
    w_hit       = (w_xov && !w_ingap) || (i_bird_y_b >= FLOOR_Y);
    w_score_evt = !r_scored && (r_pipe_x_r < i_bird_x_l);
    // x^8 + x^6 + x^5 + x^4 + 1: maximal length, so the all-zero state is never reached
    w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    w_gap_new   = GAP_MIN + {2'b00, r_lfsr};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_pipe_x_l <= SCREEN_W;
      r_pipe_x_r <= SCREEN_W + PIPE_W;
      r_gap_y_t  <= GAP_MIN;
      r_gap_y_b  <= GAP_MIN + GAP_H;
      r_score    <= 8'd0;
      r_scored   <= 1'b0;
      r_lfsr     <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_RUN;
            r_pipe_x_l <= SCREEN_W;
            r_pipe_x_r <= SCREEN_W + PIPE_W;
            r_gap_y_t  <= GAP_MIN;
            r_gap_y_b  <= GAP_MIN + GAP_H;
            r_score    <= 8'd0;
            r_scored   <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_hit) begin
            r_state <= S_HIT;
          end else begin
            if (w_score_evt) begin
              if (r_score != 8'hFF) r_score <= r_score + 8'd1;
              r_scored <= 1'b1;
            end
            // A respawn on the same edge as a score clears scored (later NBA wins)
            if (i_tick) begin
              if (r_pipe_x_l < SPEED) begin
                r_pipe_x_l <= SCREEN_W;
                r_pipe_x_r <= SCREEN_W + PIPE_W;
                r_gap_y_t  <= w_gap_new;
                r_gap_y_b  <= w_gap_new + GAP_H;
                r_scored   <= 1'b0;
              end else begin
                r_pipe_x_l <= r_pipe_x_l - SPEED;
                r_pipe_x_r <= r_pipe_x_l - SPEED + PIPE_W;
              end
            end
          end
        end
        S_HIT: begin
          if (i_ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_q_idle   = r_state[0];
  assign o_q_run    = r_state[1];
  assign o_q_hit    = r_state[2];
  assign o_stop     = r_state[2];
  assign o_pipe_x_l = r_pipe_x_l;
  assign o_pipe_x_r = r_pipe_x_r;
  assign o_gap_y_t  = r_gap_y_t;
  assign o_gap_y_b  = r_gap_y_b;
  assign o_score    = r_score;

endmodule

// File: tb/tb_pipe_collision_ctrl.sv
// Directed bench for pipe_collision_ctrl with an abstract game model checked every cycle.
module tb_pipe_collision_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       ack = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] bxl = '0, bxr = '0, byt = '0, byb = '0;
  logic       stop, q_idle, q_run, q_hit;
  logic [9:0] px_l, px_r, gy_t, gy_b;
  logic [7:0] score;

  int n_chk = 0;
  int n_err = 0;

  // Model: game phase 0=Idle 1=Run 2=Hit, pipe left edge, gap top, score, scored flag, lfsr
  int         m_state;
  int         m_px;
  int         m_gt;
  int         m_score;
  bit         m_scored;
  logic [7:0] m_lfsr;

  always #5 clk = ~clk;

  pipe_collision_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_ack(ack), .i_tick(tick),
    .i_bird_x_l(bxl), .i_bird_x_r(bxr), .i_bird_y_t(byt), .i_bird_y_b(byb),
    .o_stop(stop), .o_pipe_x_l(px_l), .o_pipe_x_r(px_r), .o_gap_y_t(gy_t),
    .o_gap_y_b(gy_b), .o_score(score), .o_q_idle(q_idle), .o_q_run(q_run), .o_q_hit(q_hit)
  );

  function automatic logic [7:0] lfsr_adv(input logic [7:0] x);
    logic [7:0] taps;
    taps = 8'hB8;
    return {x[6:0], ^(x & taps)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int  bl, br, bt, bb;
    bit  collide;
    logic [7:0] nl;
    bl = int'(bxl); br = int'(bxr); bt = int'(byt); bb = int'(byb);
    if (reset) begin
      m_state = 0; m_px = 640; m_gt = 40; m_score = 0; m_scored = 0; m_lfsr = 8'hA5;
      return;
    end
    nl = lfsr_adv(m_lfsr);
    if (m_state == 0) begin
      if (start) begin
        m_state = 1; m_px = 640; m_gt = 40; m_score = 0; m_scored = 0;
      end
    end else if (m_state == 1) begin
      collide = ((br > m_px) && (bl < m_px + 60) && !((bt >= m_gt) && (bb <= m_gt + 120)))
                || (bb >= 480);
      if (collide) m_state = 2;
      else begin
        if (!m_scored && (m_px + 60 < bl)) begin
          m_score = (m_score == 255) ? 255 : m_score + 1;
          m_scored = 1;
        end
        if (tick) begin
          if (m_px < 4) begin
            m_px = 640; m_gt = 40 + int'(m_lfsr); m_scored = 0;
          end else m_px = m_px - 4;
        end
      end
    end else begin
      if (ack) m_state = 0;
    end
    m_lfsr = nl;
  endtask

  task automatic cmp_all();
    bit ok;
    ok = (q_idle == (m_state == 0)) && (q_run == (m_state == 1)) && (q_hit == (m_state == 2))
         && (stop == (m_state == 2)) && (int'(px_l) == m_px) && (int'(px_r) == m_px + 60)
         && (int'(gy_t) == m_gt) && (int'(gy_b) == m_gt + 120) && (int'(score) == m_score);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL cycle_model t=%0t: got st=%b%b%b stop=%b px=%0d..%0d gap=%0d..%0d score=%0d expected st=%0d px=%0d..%0d gap=%0d..%0d score=%0d",
               $time, q_hit, q_run, q_idle, stop, px_l, px_r, gy_t, gy_b, score,
               m_state, m_px, m_px + 60, m_gt, m_gt + 120, m_score);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic set_bird(input int xl, input int xr, input int yt, input int yb);
    bxl = 10'(xl); bxr = 10'(xr); byt = 10'(yt); byb = 10'(yb);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_idle"}, int'(q_idle), 1);
    chk({tag, "_stop"}, int'(stop), 0);
    chk({tag, "_pxl"}, int'(px_l), 640);
    chk({tag, "_pxr"}, int'(px_r), 700);
    chk({tag, "_gyt"}, int'(gy_t), 40);
    chk({tag, "_gyb"}, int'(gy_b), 160);
    chk({tag, "_score"}, int'(score), 0);
  endtask

  initial begin
    int guard;
    logic [7:0] lf_pre;

    // Reset state
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_reset_vals("reset");
    reset = 1'b0;

    // Start and scroll 10 ticks with the bird well clear of the pipe
    set_bird(100, 120, 60, 80);
    start = 1'b1; step(); start = 1'b0;
    chk("run_entry", int'(q_run), 1);
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
    chk("px_after_10", int'(px_l), 600);
    chk("stop_after_10", int'(stop), 0);
    chk("run_after_10", int'(q_run), 1);

    // Bird above the gap: collides when the pipe reaches x=116
    set_bird(100, 120, 0, 20);
    tick = 1'b1;
    guard = 0;
    while (m_px != 116 && guard < 400) begin step(); guard++; end
    chk("px_reach_116", int'(px_l), 116);
    chk("no_stop_yet", int'(stop), 0);
    step();
    chk("stop_on_hit", int'(stop), 1);
    chk("px_frozen_hit", int'(px_l), 116);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stop_held", int'(stop), 1);
    end
    start = 1'b0;
    tick = 1'b0;
    chk("px_still_116", int'(px_l), 116);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_to_idle", int'(q_idle), 1);
    chk("stop_released", int'(stop), 0);
    chk("score_kept", int'(score), 0);

    // Fly through the gap: score once, then respawn
    set_bird(100, 120, 60, 80);
    start = 1'b1; step(); start = 1'b0;
    chk("round2_px", int'(px_l), 640);
    tick = 1'b1;
    guard = 0;
    while (m_px != 36 && guard < 400) begin step(); guard++; end
    chk("px_reach_36", int'(px_l), 36);
    chk("score_before_pass", int'(score), 0);
    step();
    chk("score_after_pass", int'(score), 1);
    chk("no_stop_in_gap", int'(stop), 0);
    guard = 0;
    while (m_px != 0 && guard < 100) begin step(); guard++; end
    chk("px_reach_0", int'(px_l), 0);
    lf_pre = m_lfsr;
    step();
    chk("respawn_px", int'(px_l), 640);
    chk("respawn_pxr", int'(px_r), 700);
    chk("respawn_gap", int'(gy_t), 40 + int'(lf_pre));
    chk("respawn_gapb", int'(gy_b), 160 + int'(lf_pre));
    chk("score_one_pass", int'(score), 1);

    // Floor hit with pipe far right; Tick on the same cycle must not move the pipe
    set_bird(100, 120, 460, 480);
    step();
    chk("floor_stop", int'(stop), 1);
    chk("floor_px_unmoved", int'(px_l), 640);
    tick = 1'b0;
    ack = 1'b1; step(); ack = 1'b0;
    chk("floor_ack_idle", int'(q_idle), 1);
    chk("floor_score_kept", int'(score), 1);

    // Reset during Run
    set_bird(100, 120, 60, 80);
    start = 1'b1; step(); start = 1'b0;
    tick = 1'b1;
    repeat (5) step();
    tick = 1'b0;
    chk("pre_reset_px", int'(px_l), 620);
    reset = 1'b1; step(); reset = 1'b0;
    chk_reset_vals("rst_run");

    // Reset during Hit
    start = 1'b1; step(); start = 1'b0;
    set_bird(100, 120, 460, 480);
    step();
    chk("hit_before_reset", int'(q_hit), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk_reset_vals("rst_hit");
    set_bird(100, 120, 60, 80);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
